hack_boot_loader: RTL
=====================

Name: hack_boot_loader

Overview:
- Boot sequencer for the Hack CPU16 core.
- Holds the CPU in reset and receives a program image as a byte stream over a valid/ready handshake.
- Writes the image word-by-word into the instruction ROM/RAM, then releases CPU reset.
- Sits between the host link (UART receiver) and the instruction memory write port; drives the CPU rst input.

Parameters:
- ADDR_W, 15, instruction memory address width (CPU pc width).
- RST_HOLD, 4, cycles cpu_rst stays high after the last ROM write (minimum 1).
- TIMEOUT, 65535, max idle cycles between bytes inside a transfer before error (minimum 2).
- AUTO_BOOT, 1, 1: leave reset straight into loading; 0: wait in IDLE for boot_req.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- boot_req  in  1  single-cycle pulse requesting a (re)load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- rom_we  out  1  instruction memory write strobe
- rom_addr  out  ADDR_W  write address
- rom_data  out  16  write data
- cpu_rst  out  1  reset to CPU16 (high = CPU held)
- busy  out  1  high in any loading/release state
- done  out  1  high in RUN
- err  out  1  high in ERROR
- words_loaded  out  ADDR_W+1  words written in current/last transfer

Behaviour:
- Reset (async): state = CNT_HI if AUTO_BOOT else IDLE. Outputs: cpu_rst=1; rx_ready=0; rom_we=0; rom_addr=0; rom_data=0; done=0; err=0; busy=AUTO_BOOT; words_loaded=0.
- Stream format, big-endian:
  - 2 bytes: word count N (16-bit).
  - Then N words, each hi byte then lo byte.
- Handshake: a byte is accepted on a cycle with rx_valid & rx_ready. rx_ready=1 only in CNT_HI, CNT_LO, DAT_HI, DAT_LO. rx_data is not sampled otherwise.
- IDLE: cpu_rst=1. boot_req -> CNT_HI.
- CNT_HI: accept byte -> count[15:8], go CNT_LO. No timeout in this state (host may be slow to start).
- CNT_LO: accept byte -> count[7:0], clear words_loaded, then next cycle evaluate:
  - N==0 -> RELEASE.
  - N > 2**ADDR_W -> ERROR.
  - otherwise -> DAT_HI.
- DAT_HI: accept byte -> rom_data[15:8], go DAT_LO.
- DAT_LO: accept byte -> rom_data[7:0], go WRITE.
- WRITE: exactly one cycle.
  - rom_we=1, rom_addr=words_loaded[ADDR_W-1:0], rom_data stable; rx_ready=0.
  - words_loaded increments on exit.
  - words_loaded==N after increment -> RELEASE, else DAT_HI.
- Throughput: at most one word every 3 cycles. Back-to-back valid bytes are accepted on consecutive cycles except during WRITE.
- RELEASE: cpu_rst=1 for RST_HOLD cycles counted from entry, then RUN.
- RUN: cpu_rst=0, done=1, busy=0. boot_req -> CNT_HI; cpu_rst rises in the same edge as the transition, done clears.
- ERROR: cpu_rst=1, err=1. No ROM writes. Only boot_req (clears err, -> CNT_HI) or rst exits.
- Timeout: the idle counter resets on every accepted byte and on state entry. In CNT_LO/DAT_HI/DAT_LO, TIMEOUT consecutive cycles without acceptance -> ERROR.
- boot_req is ignored in CNT_HI..RELEASE (no restart mid-transfer).
- rst mid-transfer: immediate return to the reset state. Partially written memory is left as is; words_loaded=0.
- busy = state in {CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, RELEASE}.
- rom_we is never high outside WRITE. rom_addr never exceeds N-1.

Decomposition:
- Shared package hack_boot_pkg:
  - state enum (IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, RELEASE, RUN, ERROR);
  - constant for the header length (2 bytes);
  - MAX_WORDS = 2**ADDR_W.
- One natural sub-module: boot_timeout_ctr. Generic down-counter with load/clear and an expired flag, used for both the inter-byte timeout and the RST_HOLD countdown.

Test Plan:
- AUTO_BOOT=1, stream 00 03 | 12 34 | AB CD | 80 01 with rx_valid always high -> rom_we pulses at addr 0, 1, 2 with data 0x1234, 0xABCD, 0x8001. words_loaded=3. cpu_rst falls RST_HOLD cycles after the last write; done=1.
- Header 00 00 -> no rom_we; RELEASE then RUN; words_loaded=0.
- Header 80 01 (N=32769 > 32768) with ADDR_W=15 -> ERROR, err=1, cpu_rst=1, no writes. Then boot_req followed by a valid stream -> successful load, err=0.
- Stall the stream after the DAT_HI byte for TIMEOUT cycles (use TIMEOUT=16) -> ERROR on cycle 16. At TIMEOUT-1 cycles the byte is still accepted normally.
- In RUN, pulse boot_req -> cpu_rst=1 and done=0 the next cycle; a reload of 00 01 | 00 07 writes 0x0007 at addr 0. A boot_req during DAT_LO has no effect.
- Assert rst after 2 of 5 words -> all outputs at reset values asynchronously. With AUTO_BOOT=0 the block stays in IDLE and rx_ready=0 until boot_req.

Source files
------------

// File: rtl/hack_boot_pkg.sv
// Shared types and constants for the Hack CPU16 boot loader.
//   bootState_t : loader FSM states
//   HDR_BYTES   : length of the big-endian word-count header
//   CNT_W       : width of the word-count field
//   maxWords()  : instruction memory depth (2**addrW)
package hack_boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    RELEASE,
    RUN,
    ERROR
  } bootState_t;

  localparam int unsigned HDR_BYTES = 2;
  localparam int unsigned CNT_W     = HDR_BYTES * 8;

  function automatic int unsigned maxWords(input int unsigned addrW);
    return 32'd1 << addrW;
  endfunction

endpackage

// File: rtl/hack_boot_loader_if.sv
// Byte-stream input plus instruction-memory write port of the boot loader.
//   master : the loader (consumes rx bytes, drives memory writes)
//   slave  : host link / memory side
interface hack_boot_loader_if #(
  parameter int unsigned ADDR_W = 15
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, rom_we, rom_addr, rom_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, rom_we, rom_addr, rom_data
  );

endinterface

// File: rtl/hack_boot_loader_boot_timeout_ctr.sv
// Down-counter with load/clear that saturates at zero.
//   clk, rst   : clock, async active-high reset
//   load       : load loadVal (priority below clr)
//   clr        : force count to zero
//   loadVal    : value to load
//   expired_c  : count has reached zero (combinational)
module boot_timeout_ctr #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] loadVal,
  output logic         expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (clr)           count <= '0;
    else if (load)          count <= loadVal;
    else if (count != '0)   count <= count - W'(1);
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/hack_boot_loader.sv
// Boot sequencer: holds CPU16 in reset, receives a big-endian image
// (16-bit word count N, then N words hi/lo) over a valid/ready byte stream,
// writes it into instruction memory and then releases the CPU.
//   clk, rst     : clock, async active-high reset
//   boot_req     : pulse requesting a (re)load from IDLE, RUN or ERROR
//   bus          : rx byte stream in, instruction memory write port out
//   cpu_rst      : CPU reset (high = held)
//   busy/done/err: loading-or-releasing / running / failed
//   words_loaded : words written in the current or last transfer
module hack_boot_loader
  import hack_boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned RST_HOLD  = 4,
  parameter int unsigned TIMEOUT   = 65535,
  parameter int unsigned AUTO_BOOT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_req,
  hack_boot_loader_if.master  bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int unsigned CTR_MAX = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
  localparam int unsigned CTR_W   = $clog2(CTR_MAX + 1);
  localparam int unsigned MAXW    = maxWords(ADDR_W);
  localparam bootState_t  RESET_STATE = (AUTO_BOOT != 0) ? CNT_HI : IDLE;

  bootState_t        state, nextState;
  logic [CNT_W-1:0]  countQ, countD;
  logic [15:0]       romDataQ, romDataD;
  logic [ADDR_W-1:0] romAddrQ, romAddrD;
  logic [ADDR_W:0]   wordsD, wordsInc;
  logic [CNT_W-1:0]  headerN;
  logic              romWeQ, rxReadyQ;
  logic              accept;
  logic              ctrLoad, ctrClr, ctrExpired;
  logic [CTR_W-1:0]  ctrLoadVal;

  assign accept   = bus.rx_valid & rxReadyQ;
  assign wordsInc = words_loaded + (ADDR_W+1)'(1);
  // Full word count as it becomes known on the CNT_LO byte
  assign headerN  = {countQ[15:8], bus.rx_data};

  // Shared counter: inter-byte timeout while loading, hold time in RELEASE
  boot_timeout_ctr #(.W(CTR_W)) uCtr (
    .clk       (clk),
    .rst       (rst),
    .load      (ctrLoad),
    .clr       (ctrClr),
    .loadVal   (ctrLoadVal),
    .expired_c (ctrExpired)
  );

  // Next-state and next-register values
  always_comb begin
    nextState  = state;
    countD     = countQ;
    romDataD   = romDataQ;
    romAddrD   = romAddrQ;
    wordsD     = words_loaded;
    ctrLoad    = 1'b0;
    ctrClr     = 1'b0;
    ctrLoadVal = CTR_W'(TIMEOUT - 1);

    case (state)
      IDLE:    if (boot_req) nextState = CNT_HI;
      CNT_HI:  if (accept) begin
                 countD[15:8] = bus.rx_data;
                 nextState    = CNT_LO;
               end
      CNT_LO:  if (accept) begin
                 countD[7:0] = bus.rx_data;
                 wordsD      = '0;
                 if (headerN == '0)                 nextState = RELEASE;
                 else if (32'(headerN) > MAXW)      nextState = ERROR;
                 else                               nextState = DAT_HI;
               end else if (ctrExpired) begin
                 nextState = ERROR;
               end
      DAT_HI:  if (accept) begin
                 romDataD[15:8] = bus.rx_data;
                 nextState      = DAT_LO;
               end else if (ctrExpired) begin
                 nextState = ERROR;
               end
      DAT_LO:  if (accept) begin
                 romDataD[7:0] = bus.rx_data;
                 romAddrD      = words_loaded[ADDR_W-1:0];
                 nextState     = WRITE;
               end else if (ctrExpired) begin
                 nextState = ERROR;
               end
      WRITE:   begin
                 wordsD    = wordsInc;
                 nextState = (32'(wordsInc) == 32'(countQ)) ? RELEASE : DAT_HI;
               end
      RELEASE: if (ctrExpired) nextState = RUN;
      RUN:     if (boot_req) nextState = CNT_HI;
      ERROR:   if (boot_req) nextState = CNT_HI;
      default: nextState = RESET_STATE;
    endcase

    // Restart the idle window on every byte and every state change
    ctrLoad = accept || (nextState != state);
    ctrClr  = (nextState inside {IDLE, RUN, ERROR});
    if (nextState == RELEASE) ctrLoadVal = CTR_W'(RST_HOLD - 1);
  end

  // State and registered outputs, decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RESET_STATE;
      countQ       <= '0;
      romDataQ     <= '0;
      romAddrQ     <= '0;
      romWeQ       <= 1'b0;
      rxReadyQ     <= 1'b0;
      cpu_rst      <= 1'b1;
      busy         <= (AUTO_BOOT != 0);
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      state        <= nextState;
      countQ       <= countD;
      romDataQ     <= romDataD;
      romAddrQ     <= romAddrD;
      romWeQ       <= (nextState == WRITE);
      rxReadyQ     <= (nextState inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO});
      cpu_rst      <= (nextState != RUN);
      busy         <= (nextState inside {CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, RELEASE});
      done         <= (nextState == RUN);
      err          <= (nextState == ERROR);
      words_loaded <= wordsD;
    end
  end

  assign bus.rx_ready = rxReadyQ;
  assign bus.rom_we   = romWeQ;
  assign bus.rom_addr = romAddrQ;
  assign bus.rom_data = romDataQ;

endmodule
